// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_lsu_pkg
// | Shared FSM states, funct3 codes, byte-strobe codes and the op-legality rule.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_CAPTURE   = 3'd2,
        S_RESP      = 3'd3,
        S_DBG_IDLE  = 3'd4,
        S_DBG_WRITE = 3'd5
    } lsu_state_t;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [3:0] WR_B = 4'h1;
    localparam logic [3:0] WR_H = 4'h3;
    localparam logic [3:0] WR_W = 4'hF;

    // Stores have no unsigned forms; loads accept the five RV32 widths.
    function automatic logic op_legal(input logic we, input logic [2:0] op);
        if (we) begin
            return (op == OP_B) || (op == OP_H) || (op == OP_W);
        end
        return (op == OP_B) || (op == OP_H) || (op == OP_W) ||
               (op == OP_BU) || (op == OP_HU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_lsu_if
// | Core request/response, debug-init and memory-side signals of the LSU.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        dbg_mode;
    logic        dbg_active;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_data0;
    logic [31:0] dbg_data1;
    logic        dbg_err;
    logic [15:0] dbg_words;

    logic [31:0] mem_address;
    logic [31:0] mem_datain1;
    logic [31:0] mem_datain2;
    logic [3:0]  mem_wr;
    logic        mem_enable_debug;
    logic [31:0] mem_dataout;

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
               dbg_mode, dbg_valid, dbg_addr, dbg_data0, dbg_data1, mem_dataout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_active, dbg_ready,
               dbg_err, dbg_words, mem_address, mem_datain1, mem_datain2, mem_wr,
               mem_enable_debug
    );

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
               dbg_mode, dbg_valid, dbg_addr, dbg_data0, dbg_data1, mem_dataout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_active, dbg_ready,
               dbg_err, dbg_words, mem_address, mem_datain1, mem_datain2, mem_wr,
               mem_enable_debug
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_lsu_align
// | Combinational op decode: store byte strobes, legality and load extension.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic        we_i,
    input  logic [31:0] dataout_i,
    output logic [3:0]  strobe_o,
    output logic        legal_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        legal_o  = op_legal(we_i, op_i);
        strobe_o = 4'h0;
        rdata_o  = dataout_i;
        case (op_i)
            OP_B: begin
                strobe_o = WR_B;
                rdata_o  = {{24{dataout_i[7]}}, dataout_i[7:0]};
            end
            OP_H: begin
                strobe_o = WR_H;
                rdata_o  = {{16{dataout_i[15]}}, dataout_i[15:0]};
            end
            OP_W: begin
                strobe_o = WR_W;
                rdata_o  = dataout_i;
            end
            OP_BU: rdata_o = {24'h0, dataout_i[7:0]};
            OP_HU: rdata_o = {16'h0, dataout_i[15:0]};
            default: ;
        endcase
        if (!we_i || !legal_o) begin
            strobe_o = 4'h0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_lsu
// | Load/store initiator for Memoria32Data with a dual-word debug-init path.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int                ADDR_W       = 12,
    parameter logic [ADDR_W-1:0] DBG_ADDR_MAX = 12'hFF8
) (
    input  logic     Clk,
    input  logic     Reset,
    mem_lsu_if.slave bus
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, data0_q, data1_q, rsp_rdata_q;
    logic [2:0]  op_q;
    logic        we_q, rsp_err_q, dbg_active_q, dbg_err_q;
    logic [15:0] dbg_words_q;

    logic [3:0]  strobe;
    logic        legal;
    logic [31:0] ext_rdata;
    logic        dbg_bad;

    mem_lsu_align u_align (
        .op_i      (op_q),
        .we_i      (we_q),
        .dataout_i (bus.mem_dataout),
        .strobe_o  (strobe),
        .legal_o   (legal),
        .rdata_o   (ext_rdata)
    );

    assign dbg_bad = (bus.dbg_addr[1:0] != 2'b00) ||
                     (bus.dbg_addr[ADDR_W-1:0] > DBG_ADDR_MAX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dbg_mode) begin
                    state_d = S_DBG_IDLE;
                end else if (bus.req_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = (we_q || !legal) ? S_RESP : S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DBG_IDLE: begin
                if (!bus.dbg_mode) begin
                    state_d = S_IDLE;
                end else if (bus.dbg_valid && !dbg_bad) begin
                    state_d = S_DBG_WRITE;
                end
            end
            S_DBG_WRITE: state_d = S_DBG_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Reset gates the strobes directly so an in-flight write never lands.
    always_comb begin
        bus.req_ready = (state_q == S_IDLE) && !dbg_active_q;
        bus.rsp_valid = (state_q == S_RESP);
        bus.dbg_ready = (state_q == S_DBG_IDLE);
        bus.mem_wr    = 4'h0;
        if (!Reset) begin
            if (state_q == S_ISSUE) begin
                bus.mem_wr = strobe;
            end else if (state_q == S_DBG_WRITE) begin
                bus.mem_wr = 4'hF;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q       <= 32'h0;
            data0_q      <= 32'h0;
            data1_q      <= 32'h0;
            op_q         <= 3'h0;
            we_q         <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
            dbg_active_q <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_words_q  <= 16'h0;
        end else begin
            dbg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.dbg_mode) begin
                        dbg_active_q <= 1'b1;
                        dbg_words_q  <= 16'h0;
                    end else if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        data0_q     <= bus.req_wdata;
                        op_q        <= bus.req_op;
                        we_q        <= bus.req_we;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                S_ISSUE:   rsp_err_q   <= !legal;
                S_CAPTURE: rsp_rdata_q <= ext_rdata;
                S_DBG_IDLE: begin
                    if (!bus.dbg_mode) begin
                        dbg_active_q <= 1'b0;
                    end else if (bus.dbg_valid) begin
                        if (dbg_bad) begin
                            dbg_err_q <= 1'b1;
                        end else begin
                            addr_q  <= bus.dbg_addr;
                            data0_q <= bus.dbg_data0;
                            data1_q <= bus.dbg_data1;
                        end
                    end
                end
                S_DBG_WRITE: begin
                    dbg_words_q <= (dbg_words_q > 16'hFFFD) ? 16'hFFFF
                                                            : dbg_words_q + 16'd2;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_rdata        = rsp_rdata_q;
    assign bus.rsp_err          = rsp_err_q;
    assign bus.dbg_active       = dbg_active_q;
    assign bus.dbg_err          = dbg_err_q;
    assign bus.dbg_words        = dbg_words_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_datain1      = data0_q;
    assign bus.mem_datain2      = data1_q;
    assign bus.mem_enable_debug = dbg_active_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------
// | tb_mem_lsu
// | Directed bench for mem_lsu with a byte-addressed rotating memory model.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_lsu_if bus();

    mem_lsu #(.ADDR_W(12), .DBG_ADDR_MAX(12'hFF8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Memory: byte 0 of Datain1/Dataout is always the byte at the address.
    logic [7:0] mem [0:4095];
    bit         mem_init_done = 1'b0;
    always @(posedge clk) begin
        logic [11:0] a;
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
            mem_init_done = 1'b1;
        end
        a = bus.mem_address[11:0];
        bus.mem_dataout <= {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
        if (bus.mem_enable_debug && bus.mem_wr == 4'hF) begin
            for (int i = 0; i < 4; i++) begin
                mem[a + 12'(i)]     = bus.mem_datain1[8*i +: 8];
                mem[a + 12'(4 + i)] = bus.mem_datain2[8*i +: 8];
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wr[i]) mem[a + 12'(i)] = bus.mem_datain1[8*i +: 8];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_wr, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int n;
        logic [3:0] wr_or;
        bus.req_we    = we;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check({tag, " issue wr"},   32'(bus.mem_wr), 32'(exp_wr));
        check({tag, " issue addr"}, bus.mem_address, addr);
        if (exp_wr != 4'h0) check({tag, " datain1"}, bus.mem_datain1, wdata);
        wr_or = bus.mem_wr;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin tick(); n++; wr_or |= bus.mem_wr; end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " wr seen"}, 32'(wr_or), 32'(exp_wr));
        check({tag, " rdata"},   bus.rsp_rdata, exp_rdata);
        check({tag, " err"},     32'(bus.rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " hold rdata"}, bus.rsp_rdata, exp_rdata);
            check({tag, " hold ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check({tag, " idle ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, " idle valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic dbg_beat(input string tag, input logic [31:0] a,
                            input logic [31:0] d0, input logic [31:0] d1, input logic bad);
        int n = 0;
        while (!bus.dbg_ready && n < 20) begin tick(); n++; end
        check({tag, " dbg_ready"}, 32'(bus.dbg_ready), 32'd1);
        bus.dbg_addr  = a;
        bus.dbg_data0 = d0;
        bus.dbg_data1 = d1;
        bus.dbg_valid = 1'b1;
        tick();
        bus.dbg_valid = 1'b0;
        if (bad) begin
            check({tag, " err pulse"}, 32'(bus.dbg_err), 32'd1);
            check({tag, " no wr"},     32'(bus.mem_wr), 32'd0);
            tick();
            check({tag, " err clear"}, 32'(bus.dbg_err), 32'd0);
        end else begin
            check({tag, " wr"},      32'(bus.mem_wr), 32'hF);
            check({tag, " addr"},    bus.mem_address, a);
            check({tag, " d0"},      bus.mem_datain1, d0);
            check({tag, " d1"},      bus.mem_datain2, d1);
            check({tag, " busy"},    32'(bus.dbg_ready), 32'd0);
            check({tag, " err low"}, 32'(bus.dbg_err), 32'd0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_op = 3'h0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
        bus.dbg_mode = 1'b0; bus.dbg_valid = 1'b0; bus.dbg_addr = 32'h0;
        bus.dbg_data0 = 32'h0; bus.dbg_data1 = 32'h0;
        repeat (3) tick();
        check("rst rsp_valid",  32'(bus.rsp_valid), 32'd0);
        check("rst rsp_err",    32'(bus.rsp_err), 32'd0);
        check("rst dbg_active", 32'(bus.dbg_active), 32'd0);
        check("rst dbg_words",  32'(bus.dbg_words), 32'd0);
        check("rst mem_wr",     32'(bus.mem_wr), 32'd0);
        check("rst mem_addr",   bus.mem_address, 32'd0);
        check("rst rdata",      bus.rsp_rdata, 32'd0);
        rst = 1'b0;
        tick();

        do_req("sw102",  1'b1, OP_W,  32'h102, 32'hDEADBEEF, WR_W, 2, 32'h0, 1'b0, 0);
        do_req("lw102",  1'b0, OP_W,  32'h102, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0, 0);
        do_req("sb203",  1'b1, OP_B,  32'h203, 32'h00000080, WR_B, 2, 32'h0, 1'b0, 0);
        do_req("lb203",  1'b0, OP_B,  32'h203, 32'h0, 4'h0, 3, 32'hFFFFFF80, 1'b0, 0);
        do_req("lbu203", 1'b0, OP_BU, 32'h203, 32'h0, 4'h0, 3, 32'h00000080, 1'b0, 0);
        do_req("sh300",  1'b1, OP_H,  32'h300, 32'h00008001, WR_H, 2, 32'h0, 1'b0, 0);
        do_req("lhu300", 1'b0, OP_HU, 32'h300, 32'h0, 4'h0, 3, 32'h00008001, 1'b0, 0);
        do_req("lh300",  1'b0, OP_H,  32'h300, 32'h0, 4'h0, 3, 32'hFFFF8001, 1'b0, 0);
        do_req("lwhold", 1'b0, OP_W,  32'h102, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0, 3);
        do_req("ld011",  1'b0, 3'b011, 32'h102, 32'h0, 4'h0, 2, 32'h0, 1'b1, 0);
        do_req("st100",  1'b1, OP_BU, 32'h500, 32'h12345678, 4'h0, 2, 32'h0, 1'b1, 0);

        // A pending load stays asserted across the whole debug session.
        bus.req_we = 1'b0; bus.req_op = OP_W; bus.req_addr = 32'h4; bus.req_valid = 1'b1;
        bus.dbg_mode = 1'b1;
        tick();
        check("dbg active",    32'(bus.dbg_active), 32'd1);
        check("dbg mem_en",    32'(bus.mem_enable_debug), 32'd1);
        check("dbg req_ready", 32'(bus.req_ready), 32'd0);
        check("dbg words0",    32'(bus.dbg_words), 32'd0);
        dbg_beat("beat000", 32'h000, 32'h11111111, 32'h22222222, 1'b0);
        check("dbg words2",    32'(bus.dbg_words), 32'd2);
        dbg_beat("beat00a", 32'h00A, 32'h33333333, 32'h44444444, 1'b1);
        dbg_beat("beatffc", 32'hFFC, 32'h55555555, 32'h66666666, 1'b1);
        check("dbg words end", 32'(bus.dbg_words), 32'd2);
        check("dbg still off", 32'(bus.req_ready), 32'd0);
        bus.dbg_mode = 1'b0;
        tick();
        check("dbg exit", 32'(bus.dbg_active), 32'd0);
        do_req("lw004", 1'b0, OP_W, 32'h4, 32'h0, 4'h0, 3, 32'h22222222, 1'b0, 0);
        do_req("lw000", 1'b0, OP_W, 32'h0, 32'h0, 4'h0, 3, 32'h11111111, 1'b0, 0);

        bus.req_we = 1'b1; bus.req_op = OP_W; bus.req_addr = 32'h400;
        bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst issue wr", 32'(bus.mem_wr), 32'd0);
        tick();
        rst = 1'b0;
        check("rst rsp_valid post", 32'(bus.rsp_valid), 32'd0);
        check("rst req_ready post", 32'(bus.req_ready), 32'd1);
        do_req("lw400", 1'b0, OP_W, 32'h400, 32'h0, 4'h0, 3, 32'h0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
